// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// serial_adder_pkg : shared FSM encodings and default width for the serial adder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // 2'd3 is unused; the controller recovers from it to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_ctrl_fa_cell.sv
//------------------------------------------------------------------------------
// fa_cell : 1-bit full adder from two half_adder instances plus a carry OR
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (.a(a),    .b(b),  .s(w_s0), .c(w_c0));
  half_adder u_ha1 (.a(w_s0), .b(ci), .s(s),    .c(w_c1));

  assign co = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// serial_adder_ctrl : bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input for A - B.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int             CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q,  a_sr_d;
  logic [WIDTH-1:0] b_sr_q,  b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cy_q,    cy_d;
  logic             cout_q,  cout_d;
  logic             done_q,  done_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             cell_s;
  logic             cell_co;

  fa_cell u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (cy_q),
    .s  (cell_s),
    .co (cell_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    cy_d     = cy_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = A;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert B and inject a carry-in of 1
          b_sr_d  = sub ? ~B : B;
          cy_d    = sub;
`else
          b_sr_d  = B;
          cy_d    = 1'b0;
`endif
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = WIDTH'({cell_s, res_sr_q} >> 1);
        cy_d     = cell_co;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        sum_d   = res_sr_q;
        cout_d  = cy_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      cy_q     <= 1'b0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      cy_q     <= cy_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_SHIFT);
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
//------------------------------------------------------------------------------
// tb_serial_adder_ctrl : randomized self-checking bench for 8-bit and 1-bit adders
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st8, st1;
  logic [7:0] a8, b8;
  logic       a1, b1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, sub1;
`endif
  logic       busy8, done8, c8;
  logic [7:0] sum8;
  logic       busy1, done1, c1;
  logic       sum1;

  int checks = 0;
  int errors = 0;

  // Last result each DUT should be holding: [0] = 8-bit, [1] = 1-bit; {carry, sum}
  logic [8:0] held [2];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub8),
`endif
    .A     (a8),
    .B     (b8),
    .busy  (busy8),
    .done  (done8),
    .Sum   (sum8),
    .Carry (c8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub1),
`endif
    .A     (a1),
    .B     (b1),
    .busy  (busy1),
    .done  (done1),
    .Sum   (sum1),
    .Carry (c1)
  );

  task automatic check(input string tag, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic on the operand width, carry in bit 8
  function automatic logic [8:0] model(input bit w1, input logic [7:0] a, input logic [7:0] b,
                                       input bit sub);
    int unsigned m;
    int unsigned aa;
    int unsigned bb;
    int unsigned r;
    logic [8:0]  res;
    m  = w1 ? 1 : 255;
    aa = a & m;
    bb = b & m;
    if (sub) begin
      r      = (aa - bb) & m;
      res[8] = (aa >= bb);
    end else begin
      r      = aa + bb;
      res[8] = (r > m);
      r      = r & m;
    end
    res[7:0] = 8'(r);
    return res;
  endfunction

  function automatic logic [8:0] obs_res(input bit w1);
    return w1 ? {c1, 7'b0, sum1} : {c8, sum8};
  endfunction

  task automatic drive_start(input bit w1, input logic v, input logic [7:0] a,
                             input logic [7:0] b, input bit sub);
    if (w1) begin
      st1 = v; a1 = a[0]; b1 = b[0];
`ifdef SERIAL_ADDER_SUB_EN
      sub1 = sub;
`endif
    end else begin
      st8 = v; a8 = a; b8 = b;
`ifdef SERIAL_ADDER_SUB_EN
      sub8 = sub;
`endif
    end
  endtask

  // pulse_at: re-assert start before edge k (must be ignored); rst_at: abort after edge k
  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b, input bit sub,
                        input int pulse_at, input int rst_at);
    int         w;
    logic [8:0] exp;
    bit         ob, od;
    w   = w1 ? 1 : 8;
    exp = model(w1, a, b, sub);
    drive_start(w1, 1'b1, a, b, sub);
    @(posedge clk); #1;
    drive_start(w1, 1'b0, 8'($urandom), 8'($urandom), bit'($urandom_range(1)));
    for (int k = 1; k <= w + 1; k++) begin
      if (k == pulse_at)
        drive_start(w1, 1'b1, 8'($urandom), 8'($urandom), bit'($urandom_range(1)));
      @(posedge clk); #1;
      if (k == pulse_at)
        drive_start(w1, 1'b0, 8'($urandom), 8'($urandom), bit'($urandom_range(1)));
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", {8'b0, (w1 ? busy1 : busy8)}, 9'd0);
        check("rst_done", {8'b0, (w1 ? done1 : done8)}, 9'd0);
        check("rst_res", obs_res(w1), 9'd0);
        held[0] = '0;
        held[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      ob = w1 ? busy1 : busy8;
      od = w1 ? done1 : done8;
      check("busy", {8'b0, ob}, {8'b0, (k < w)});
      check("done", {8'b0, od}, {8'b0, (k == w + 1)});
      check("result", obs_res(w1), (k == w + 1) ? exp : held[w1]);
    end
    held[w1] = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_rand;
    bit w1;
    bit sb;
    int pa;
    int ra;
    rst_n = 1'b0;
    st8 = 1'b0; st1 = 1'b0;
    a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub1 = 1'b0;
`endif
    held[0] = '0;
    held[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy8", {8'b0, busy8}, 9'd0);
    check("reset_done8", {8'b0, done8}, 9'd0);
    check("reset_res8",  obs_res(1'b0), 9'd0);
    check("reset_busy1", {8'b0, busy1}, 9'd0);
    check("reset_done1", {8'b0, done1}, 9'd0);
    check("reset_res1",  obs_res(1'b1), 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 8'h5A, 8'h3C, 1'b0, 0, 0);
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, 0, 0);
    run_op(1'b0, 8'h12, 8'h34, 1'b0, 3, 0);
    run_op(1'b0, 8'hA5, 8'h77, 1'b0, 0, 4);
    run_op(1'b0, 8'h80, 8'h80, 1'b0, 0, 0);
    run_op(1'b0, 8'hFF, 8'hFF, 1'b0, 9, 0);
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 8'(i & 1), 8'(i >> 1), 1'b0, 0, 0);
`ifdef SERIAL_ADDER_SUB_EN
    run_op(1'b0, 8'h05, 8'h07, 1'b1, 0, 0);
    run_op(1'b0, 8'h07, 8'h05, 1'b1, 0, 0);
    run_op(1'b0, 8'h33, 8'h33, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++)
      run_op(1'b1, 8'(i & 1), 8'(i >> 1), 1'b1, 0, 0);
`endif

    n_rand = 60;
    for (int i = 0; i < n_rand; i++) begin
      w1 = ($urandom_range(3) == 0);
`ifdef SERIAL_ADDER_SUB_EN
      sb = bit'($urandom_range(1));
`else
      sb = 1'b0;
`endif
      pa = ($urandom_range(2) == 0) ? int'($urandom_range(w1 ? 2 : 9, 1)) : 0;
      ra = ($urandom_range(9) == 0) ? int'($urandom_range(w1 ? 1 : 8, 1)) : 0;
      run_op(w1, 8'($urandom), 8'($urandom), sb, pa, ra);
    end

    @(posedge clk); #1;
    check("final_done8", {8'b0, done8}, 9'd0);
    check("final_done1", {8'b0, done1}, 9'd0);
    check("final_res8", obs_res(1'b0), held[0]);
    check("final_res1", obs_res(1'b1), held[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
